// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: shares the 8088 local bus between the CPU and NUM_REQ bus
// masters using the minimum-mode HOLD/HLDA handshake. Masters are granted one
// at a time in round-robin order. Each tenure is bounded by MAX_TENURE cycles.
// After every tenure the bus goes back through a turnaround cycle and a
// CPU-fairness gap.
module bus_hold_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int MAX_TENURE = 16,
  parameter  int GAP_CYCLES = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               HLDA,
  output logic               HOLD,
  output logic [NUM_REQ-1:0] GNT,
  output logic [ID_W-1:0]    GNT_ID,
  output logic               BUSY,
  output logic               TIMEOUT,
  output logic               ERR
);

  localparam int TEN_W = $clog2(MAX_TENURE);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

  localparam logic [NUM_REQ-1:0] GNT_LSB    = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    PTR_RESET  = ID_W'(NUM_REQ - 1);
  localparam logic [TEN_W-1:0]   TEN_LAST   = TEN_W'(MAX_TENURE - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD_REQ,
    S_GRANT,
    S_RELEASE,
    S_WAIT_HLDA,
    S_GAP
  } state_t;

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic [TEN_W-1:0] ten_cnt;
  logic [GAP_W-1:0] gap_cnt;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             ten_last;
  logic             gnt_req;

  // Round-robin winner: first set REQ bit after the pointer, wrapping.
  // Scanning from the far end down lets the nearest candidate win last.
  // NOTE: every always_comb output gets a default up front so no path can leave
  // a variable unassigned, which would infer a latch.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (REQ[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign ten_last = (ten_cnt == TEN_LAST);
  assign gnt_req  = REQ[GNT_ID];

  // Arbitration FSM with all outputs registered.
  // NOTE: state and outputs are updated with non-blocking assignments so every
  // branch reads the values from before this edge, whatever the statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      ptr     <= PTR_RESET;
      ten_cnt <= '0;
      gap_cnt <= '0;
      HOLD    <= 1'b0;
      GNT     <= '0;
      GNT_ID  <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      TIMEOUT <= 1'b0;
      ERR     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            state <= S_HOLD_REQ;
            HOLD  <= 1'b1;
            BUSY  <= 1'b1;
          end
        end

        S_HOLD_REQ: begin
          if (HLDA) begin
            if (win_found) begin
              state   <= S_GRANT;
              GNT     <= GNT_LSB << win_id;
              GNT_ID  <= win_id;
              ptr     <= win_id;
              ten_cnt <= '0;
            end else begin
              // Requests withdrawn while waiting: hand the bus straight back.
              state <= S_RELEASE;
            end
          end
        end

        S_GRANT: begin
          ten_cnt <= ten_cnt + 1'b1;
          if (!HLDA) begin
            // CPU took the bus back under a live grant: abandon at once.
            state   <= S_GAP;
            GNT     <= '0;
            HOLD    <= 1'b0;
            ERR     <= 1'b1;
            gap_cnt <= '0;
          end else if (!gnt_req || ten_last) begin
            state   <= S_RELEASE;
            GNT     <= '0;
            TIMEOUT <= gnt_req && ten_last;
          end
        end

        S_RELEASE: begin
          // HOLD stays high for this turnaround cycle so the master can tri-state.
          state <= S_WAIT_HLDA;
          HOLD  <= 1'b0;
        end

        S_WAIT_HLDA: begin
          if (!HLDA) begin
            state   <= S_GAP;
            gap_cnt <= '0;
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
          HOLD  <= 1'b0;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Testbench for bus_hold_arbiter: a small CPU model answers HOLD with HLDA
// after a programmable latency, and a monitor pops expected grant ids from a
// scoreboard queue whenever a new grant appears.
module tb_bus_hold_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int MAX_TENURE = 16;
  localparam int GAP_CYCLES = 2;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] REQ = 4'b0000;
  logic       HLDA = 1'b0;
  logic       HOLD;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       TIMEOUT;
  logic       ERR;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  int         hlda_lat = 2;
  bit         force_low = 1'b0;
  logic [7:0] hist = '0;

  bus_hold_arbiter #(
    .NUM_REQ(NUM_REQ),
    .MAX_TENURE(MAX_TENURE),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .REQ(REQ),
    .HLDA(HLDA),
    .HOLD(HOLD),
    .GNT(GNT),
    .GNT_ID(GNT_ID),
    .BUSY(BUSY),
    .TIMEOUT(TIMEOUT),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // CPU model: HLDA follows HOLD by hlda_lat edges; force_low models a violation.
  initial forever begin
    @(posedge CLK);
    #2;
    if (!RESET_N) begin
      hist = '0;
      HLDA = 1'b0;
    end else begin
      hist = {hist[6:0], HOLD};
      HLDA = hist[hlda_lat-1] & ~force_low;
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on each new grant.
  logic [3:0] prev_gnt = '0;
  logic       prev_hold = 1'b0;
  initial forever begin
    @(posedge CLK);
    #3;
    checks++;
    if (!$onehot0(GNT)) begin
      failures++;
      $display("FAIL onehot0 got=%b", GNT);
    end
    checks++;
    if (GNT != 4'b0000 && HOLD !== 1'b1) begin
      failures++;
      $display("FAIL gnt_implies_hold got hold=%b gnt=%b exp hold=1", HOLD, GNT);
    end
    if (GNT != 4'b0000 && prev_gnt == 4'b0000) begin
      checks++;
      if (prev_hold !== 1'b1) begin
        failures++;
        $display("FAIL gnt_same_edge_as_hold got prev_hold=%b exp=1", prev_hold);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_grant got gnt_id=%0d exp=none", GNT_ID);
      end else begin
        int         exp_id;
        logic [3:0] exp_gnt;
        exp_id  = exp_q.pop_front();
        exp_gnt = 4'b0001 << exp_id;
        if (GNT_ID !== 2'(exp_id) || GNT !== exp_gnt) begin
          failures++;
          $display("FAIL grant_order got id=%0d gnt=%b exp id=%0d gnt=%b",
                   GNT_ID, GNT, exp_id, exp_gnt);
        end
      end
    end
    prev_gnt  = GNT;
    prev_hold = HOLD;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_gnt(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (GNT != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    RESET_N   = 1'b0;
    REQ       = 4'b0000;
    force_low = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tick();
    checks++;
    if (HOLD !== 1'b0 || GNT !== 4'b0000) begin
      failures++;
      $display("FAIL reset_hold_gnt got hold=%b gnt=%b exp 0 0000", HOLD, GNT);
    end
    checks++;
    if (GNT_ID !== 2'd0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_id_busy got id=%0d busy=%b exp 0 0", GNT_ID, BUSY);
    end
    checks++;
    if (TIMEOUT !== 1'b0 || ERR !== 1'b0) begin
      failures++;
      $display("FAIL reset_pulses got to=%b err=%b exp 0 0", TIMEOUT, ERR);
    end
    RESET_N = 1'b1;
    repeat (3) tick();
    checks++;
    if (HOLD !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got hold=%b busy=%b exp 0 0", HOLD, BUSY);
    end
  endtask

  task automatic test_single();
    bit ok;
    bit bad;
    do_reset();
    hlda_lat = 3;
    exp_q.push_back(0);
    REQ = 4'b0001;
    tick();
    checks++;
    if (HOLD !== 1'b1 || GNT !== 4'b0000 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL hold_latency got hold=%b gnt=%b busy=%b exp 1 0000 1", HOLD, GNT, BUSY);
    end
    bad = 1'b0;
    repeat (2) begin
      tick();
      if (GNT !== 4'b0000) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL early_grant got=granted exp=no grant before hlda");
    end
    tick();
    checks++;
    if (GNT !== 4'b0001 || GNT_ID !== 2'd0) begin
      failures++;
      $display("FAIL grant_on_hlda got gnt=%b id=%0d exp 0001 0", GNT, GNT_ID);
    end
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (GNT !== 4'b0001) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL grant_held got gnt=%b exp 0001", GNT);
    end
    REQ = 4'b0000;
    tick();
    checks++;
    if (GNT !== 4'b0000 || HOLD !== 1'b1 || TIMEOUT !== 1'b0) begin
      failures++;
      $display("FAIL single_release got gnt=%b hold=%b to=%b exp 0000 1 0", GNT, HOLD, TIMEOUT);
    end
    tick();
    checks++;
    if (HOLD !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL single_hold_fall got hold=%b busy=%b exp 0 1", HOLD, BUSY);
    end
    wait_idle(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL single_idle got busy=%b exp 0", BUSY);
    end
  endtask

  task automatic test_round_robin();
    int order[6] = '{0, 1, 3, 0, 1, 3};
    bit ok;
    int low;
    do_reset();
    hlda_lat = 2;
    foreach (order[k]) exp_q.push_back(order[k]);
    REQ = 4'b1011;
    for (int t = 0; t < 6; t++) begin
      wait_gnt(60, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL rr_grant_wait tenure=%0d got=no grant exp=grant", t);
      end
      repeat (2) tick();
      REQ[order[t]] = 1'b0;
      if (t == 5) begin
        REQ = 4'b0000;
      end else begin
        low = 0;
        for (int i = 0; i < 60; i++) begin
          tick();
          if (HOLD === 1'b0) low++;
          if (BUSY === 1'b0) REQ[order[t]] = 1'b1;
          if (HOLD === 1'b1 && low > 0) break;
        end
        checks++;
        if (low < GAP_CYCLES) begin
          failures++;
          $display("FAIL rr_hold_gap tenure=%0d got=%0d exp>=%0d", t, low, GAP_CYCLES);
        end
      end
    end
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rr_idle got busy=%b exp 0", BUSY);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int len;
    int to_cnt;
    do_reset();
    hlda_lat = 2;
    exp_q.push_back(2);
    exp_q.push_back(2);
    REQ = 4'b0100;
    wait_gnt(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL to_grant_wait got=no grant exp=grant");
    end
    len    = 0;
    to_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (GNT[2] !== 1'b1) break;
      len++;
      tick();
      if (TIMEOUT === 1'b1) to_cnt++;
    end
    checks++;
    if (len != MAX_TENURE) begin
      failures++;
      $display("FAIL tenure_length got=%0d exp=%0d", len, MAX_TENURE);
    end
    checks++;
    if (TIMEOUT !== 1'b1 || GNT !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_edge got to=%b gnt=%b exp 1 0000", TIMEOUT, GNT);
    end
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (GNT != 4'b0000) begin
        ok = 1'b1;
        break;
      end
      tick();
      if (TIMEOUT === 1'b1) to_cnt++;
    end
    checks++;
    if (!ok || to_cnt != 1) begin
      failures++;
      $display("FAIL regrant got regrant=%b pulses=%0d exp 1 1", ok, to_cnt);
    end
    REQ = 4'b0000;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL to_idle got busy=%b exp 0", BUSY);
    end
  endtask

  task automatic test_withdrawn();
    bit ok;
    do_reset();
    hlda_lat = 2;
    REQ = 4'b0010;
    tick();
    REQ = 4'b0000;
    checks++;
    if (HOLD !== 1'b1) begin
      failures++;
      $display("FAIL wd_hold got=%b exp=1", HOLD);
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (HLDA === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || GNT !== 4'b0000 || HOLD !== 1'b1) begin
      failures++;
      $display("FAIL wd_no_grant got hlda=%b gnt=%b hold=%b exp 1 0000 1", ok, GNT, HOLD);
    end
    tick();
    checks++;
    if (HOLD !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL wd_release got hold=%b busy=%b exp 0 1", HOLD, BUSY);
    end
    wait_idle(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wd_idle got busy=%b exp 0", BUSY);
    end
  endtask

  task automatic test_hlda_violation();
    bit ok;
    do_reset();
    hlda_lat = 2;
    exp_q.push_back(3);
    REQ = 4'b1000;
    wait_gnt(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL viol_grant_wait got=no grant exp=grant");
    end
    repeat (3) tick();
    force_low = 1'b1;
    tick();
    checks++;
    if (GNT !== 4'b0000 || ERR !== 1'b1 || HOLD !== 1'b0 || TIMEOUT !== 1'b0) begin
      failures++;
      $display("FAIL viol_edge got gnt=%b err=%b hold=%b to=%b exp 0000 1 0 0",
               GNT, ERR, HOLD, TIMEOUT);
    end
    REQ = 4'b0000;
    tick();
    checks++;
    if (ERR !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL viol_pulse got err=%b busy=%b exp 0 1", ERR, BUSY);
    end
    wait_idle(20, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL viol_idle got busy=%b exp 0", BUSY);
    end
    force_low = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    hlda_lat = 2;
    exp_q.push_back(2);
    REQ = 4'b0100;
    wait_gnt(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_grant_wait got=no grant exp=grant");
    end
    tick();
    #3 RESET_N = 1'b0;
    #1;
    checks++;
    if (HOLD !== 1'b0 || GNT !== 4'b0000 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got hold=%b gnt=%b busy=%b exp 0 0000 0", HOLD, GNT, BUSY);
    end
    REQ = 4'b0110;
    exp_q.push_back(1);
    repeat (2) tick();
    RESET_N = 1'b1;
    wait_gnt(30, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_regrant got=no grant exp=grant");
    end
    REQ = 4'b0000;
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_idle got busy=%b exp 0", BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_withdrawn();
    test_hlda_violation();
    test_reset_mid();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
- Shares the 8088 local bus between the CPU and up to NUM_REQ bus masters (DMA engines, test loaders) using the minimum-mode HOLD/HLDA handshake.
- Raises HOLD toward the processor and waits for HLDA. It then grants the bus to one requester at a time in round-robin order, bounds each tenure, and returns the bus through a fixed turnaround.
- Sits in the top level beside the address latch and chip-select decode. GNT gates each master's drive onto the A/AD, RD, WR and IOM lines.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- MAX_TENURE, 16: maximum CLK cycles one grant may last (>=2).
- GAP_CYCLES, 2: minimum CLK cycles with HOLD low before HOLD may be raised again (>=1).

Ports:
- CLK  input  1  bus clock, all state changes on posedge.
- RESET_N  input  1  asynchronous reset, active low.
- REQ  input  NUM_REQ  level request per master; held high while the master wants the bus.
- HLDA  input  1  hold acknowledge from the Intel8088.
- HOLD  output  1  hold request to the Intel8088.
- GNT  output  NUM_REQ  one-hot grant, at most one bit set.
- GNT_ID  output  $clog2(NUM_REQ)  index of the current or last granted master.
- BUSY  output  1  high in any state other than IDLE.
- TIMEOUT  output  1  one-cycle pulse when a tenure is ended by MAX_TENURE.
- ERR  output  1  one-cycle pulse when HLDA drops while a grant is active.

Behaviour:
- Clock and reset: one clock (CLK); reset is asynchronous and active-low (RESET_N).
- Reset values:
  - HOLD=0, GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, ERR=0.
  - State=IDLE, tenure counter=0, gap counter=0.
  - Round-robin pointer=NUM_REQ-1, so requester 0 wins first.
- Reset mid-operation drops HOLD and GNT immediately (asynchronously).
- All outputs are registered.
- IDLE:
  - If |REQ, go to HOLD_REQ; HOLD=1 from the next edge (1-cycle latency).
- HOLD_REQ:
  - HOLD=1; wait for HLDA=1 (no timeout).
  - On the edge where HLDA=1: select the winner, the first set REQ bit searching pointer+1, pointer+2, ... modulo NUM_REQ.
  - Winner found: go to GRANT. GNT[winner]=1 and GNT_ID=winner from that edge; pointer=winner; tenure counter=0.
  - REQ==0 at that edge (requests withdrawn): go to RELEASE with no grant.
- GRANT:
  - The tenure counter increments every cycle.
  - End of tenure:
    - REQ[GNT_ID]=0: normal end.
    - Or the counter reaches MAX_TENURE-1: TIMEOUT pulses on the same edge that clears GNT.
    - GNT is cleared on the next edge and the state goes to RELEASE.
  - A GNT'd master that drops REQ gets exactly 1 further cycle of GNT.
  - Other REQ bits are ignored during GRANT.
  - HLDA=0 while in GRANT:
    - On the next edge: GNT=0, ERR pulse, HOLD=0.
    - Go to GAP.
- RELEASE:
  - GNT=0, HOLD held at 1 for one cycle (bus turnaround so the master can tri-state).
  - Then HOLD=0 and go to WAIT_HLDA.
- WAIT_HLDA:
  - HOLD=0; wait for HLDA=0.
  - Then go to GAP with gap counter=0.
- GAP:
  - HOLD=0; count GAP_CYCLES cycles, then go to IDLE.
  - Pending requests are served on the next arbitration, which enforces fairness to the CPU between tenures.
- Round robin:
  - The pointer changes only on a grant.
  - A requester that just finished is lowest priority at the next arbitration.
- Invariants:
  - GNT!=0 implies HOLD=1 and state=GRANT.
  - $onehot0(GNT) always holds.
  - GNT never rises on the same edge that HOLD rises.

Test Plan:
- Single request: REQ=4'b0001 held 5 cycles after HLDA, HLDA returned 3 cycles after HOLD.
  - HOLD rises 1 cycle after REQ; GNT=0001 and GNT_ID=0 on the edge HLDA is seen.
  - REQ drop leaves GNT for 1 more cycle, then HOLD stays high 1 cycle, then falls.
- Round robin: REQ=4'b1011 held continuously, HLDA follows HOLD with 2-cycle latency, each winner drops REQ after 3 cycles and reasserts it after the gap.
  - Grant order is 0, 1, 3, 0, 1, 3.
  - HOLD is low for at least GAP_CYCLES=2 between tenures.
- Timeout: REQ[2] held high forever.
  - GNT[2] lasts exactly MAX_TENURE=16 cycles; TIMEOUT pulses once.
  - A re-grant to 2 follows after RELEASE, WAIT_HLDA and GAP when no other requester is active.
- Withdrawn request: REQ[1] pulsed for 1 cycle only.
  - HOLD rises; on HLDA no GNT is issued.
  - HOLD is held 1 cycle then released; BUSY returns to 0 after the gap.
- HLDA violation: force HLDA=0 on the 4th cycle of a grant to requester 3.
  - Next edge: GNT=0, ERR=1 for one cycle, HOLD=0; state reaches IDLE after GAP.
- Reset mid-tenure: assert RESET_N=0 asynchronously while GNT=0100.
  - HOLD, GNT, BUSY drop without a clock edge.
  - After release, REQ=4'b0110 grants requester 1 first (pointer reset).
